// File: rtl/synth_pkg.sv
// Shared types and constants for the MIDI synthesizer voice datapath.
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam int BEND_UNITY = 8192;
  localparam int BEND_W     = 14;
  localparam int G_W        = 14;
  localparam int VEL_W      = 7;

endpackage

// File: rtl/voice_sweep_engine_if.sv
// Note on/off command port from the Avalon bridge (valid/ready handshake).
interface voice_sweep_engine_if
  import synth_pkg::*;
#(
  parameter int KEY_W = 7
) ();

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [KEY_W-1:0] CMD_KEY;
  logic             CMD_ON;
  logic [VEL_W-1:0] CMD_VEL;

  modport master (output CMD_VALID, CMD_KEY, CMD_ON, CMD_VEL, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_KEY, CMD_ON, CMD_VEL, output CMD_READY);

endinterface

// File: rtl/voice_sweep_engine_env_step.sv
// Combinational ADSR step for one voice: next amplitude and next envelope state.
module env_step
  import synth_pkg::*;
#(
  parameter int AMP_W = 21
) (
  input  env_state_t       state,
  input  logic [AMP_W-1:0] amp,
  input  logic [AMP_W-1:0] peak_att,
  input  logic [AMP_W-1:0] att_step,
  input  logic [AMP_W-1:0] dec_step,
  input  logic [AMP_W-1:0] sus_level,
  input  logic [AMP_W-1:0] sus_step,
  input  logic [AMP_W-1:0] rel_step,
  output env_state_t       next_state,
  output logic [AMP_W-1:0] next_amp
);

  logic [AMP_W:0] att_sum;
  logic [AMP_W:0] dec_floor;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    next_state = state;
    next_amp   = amp;
    att_sum    = {1'b0, amp} + {1'b0, att_step};
    dec_floor  = {1'b0, sus_level} + {1'b0, dec_step};
    case (state)
      ENV_ATTACK: begin
        if (att_sum >= {1'b0, peak_att}) begin
          next_amp   = peak_att;
          next_state = ENV_DECAY;
        end else begin
          next_amp = att_sum[AMP_W-1:0];
        end
      end
      ENV_DECAY: begin
        if ({1'b0, amp} <= dec_floor) begin
          next_amp   = sus_level;
          next_state = ENV_SUSTAIN;
        end else begin
          next_amp = amp - dec_step;
        end
      end
      ENV_SUSTAIN: begin
        if (amp <= sus_step) begin
          next_amp   = '0;
          next_state = ENV_IDLE;
        end else begin
          next_amp = amp - sus_step;
        end
      end
      ENV_RELEASE: begin
        if (amp <= rel_step) begin
          next_amp   = '0;
          next_state = ENV_IDLE;
        end else begin
          next_amp = amp - rel_step;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/voice_sweep_engine.sv
// Polyphonic voice engine: per TICK, sweeps all voice slots through a two-stage
// pipeline (phase/envelope update, then weighted saturating mix).
module voice_sweep_engine
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = 128,
  parameter  int PHASE_W    = 24,
  parameter  int AMP_W      = 21,
  parameter  int SAMPLE_W   = 16,
  parameter  int ACC_W      = 32,
  parameter  int ADDR_W     = 12,
  localparam int KEY_W      = $clog2(NUM_VOICES)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       TICK,
  voice_sweep_engine_if.slave        cmd,
  output logic [KEY_W-1:0]           F_KEY,
  input  logic [PHASE_W-1:0]         F_STEP,
  input  logic [BEND_W-1:0]          BEND,
  input  logic [AMP_W-1:0]           PEAK_ATT,
  input  logic [AMP_W-1:0]           ATT_STEP,
  input  logic [AMP_W-1:0]           DEC_STEP,
  input  logic [AMP_W-1:0]           SUS_LEVEL,
  input  logic [AMP_W-1:0]           SUS_STEP,
  input  logic [AMP_W-1:0]           REL_STEP,
  output logic [ADDR_W-1:0]          WAVE_ADDR,
  input  logic signed [SAMPLE_W-1:0] WAVE_DATA,
  output logic signed [ACC_W-1:0]    SAMPLE,
  output logic                       SAMPLE_VALID,
  output logic                       BUSY,
  output logic                       OVERRUN
);

  localparam int PROD_W     = PHASE_W + BEND_W;
  localparam int BEND_SHIFT = $clog2(BEND_UNITY);
  localparam int AV_W       = AMP_W + VEL_W;
  localparam int CONTRIB_W  = SAMPLE_W + G_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_DRAIN} sweep_state_t;

  sweep_state_t     sw_q, sw_d;
  logic [KEY_W-1:0] idx_q, idx_d;

  // Sweep sequencer: SW_RUN issues stage 0 for each voice, SW_DRAIN finishes the last stage 1.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_q  <= SW_IDLE;
      idx_q <= '0;
    end else begin
      sw_q  <= sw_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    sw_d  = sw_q;
    idx_d = idx_q;
    case (sw_q)
      SW_IDLE: begin
        if (TICK) begin
          sw_d  = SW_RUN;
          idx_d = '0;
        end
      end
      SW_RUN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == KEY_W'(NUM_VOICES - 1)) sw_d = SW_DRAIN;
      end
      SW_DRAIN: sw_d = SW_IDLE;
      default:  sw_d = SW_IDLE;
    endcase
  end

  logic stage0, cmd_fire, note_on, tick_start;
  logic [KEY_W-1:0] cmd_key;

  assign BUSY          = (sw_q != SW_IDLE);
  assign cmd.CMD_READY = !BUSY;
  assign stage0        = (sw_q == SW_RUN);
  assign tick_start    = TICK && !BUSY;
  assign cmd_fire      = cmd.CMD_VALID && !BUSY;
  assign cmd_key       = cmd.CMD_KEY;
  assign note_on       = cmd_fire && cmd.CMD_ON && (cmd.CMD_VEL != '0);

  // Per-voice storage
  env_state_t        state_mem [NUM_VOICES];
  logic [AMP_W-1:0]   amp_mem   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_mem [NUM_VOICES];
  logic [VEL_W-1:0]   vel_mem   [NUM_VOICES];
  logic [NUM_VOICES-1:0] init_q;

  env_state_t         rd_state, nxt_state;
  logic [AMP_W-1:0]   rd_amp, nxt_amp;
  logic [PHASE_W-1:0] rd_phase, nxt_phase, phase_inc;
  logic [VEL_W-1:0]   rd_vel;
  logic [PROD_W-1:0]  bend_prod;
  logic [AV_W-1:0]    amp_vel;
  logic [G_W-1:0]     g_d;

  assign rd_state  = state_mem[idx_q];
  assign rd_amp    = init_q[idx_q] ? amp_mem[idx_q]   : '0;
  assign rd_phase  = init_q[idx_q] ? phase_mem[idx_q] : '0;
  assign rd_vel    = init_q[idx_q] ? vel_mem[idx_q]   : '0;

  assign F_KEY     = idx_q;
  assign WAVE_ADDR = rd_phase[PHASE_W-1 -: ADDR_W];

  assign bend_prod = {{BEND_W{1'b0}}, F_STEP} * {{PHASE_W{1'b0}}, BEND};
  assign phase_inc = (rd_state != ENV_IDLE) ? PHASE_W'(bend_prod >> BEND_SHIFT) : '0;
  assign nxt_phase = rd_phase + phase_inc;

  assign amp_vel   = {{VEL_W{1'b0}}, rd_amp} * {{AMP_W{1'b0}}, rd_vel};
  assign g_d       = (rd_state != ENV_IDLE) ? G_W'(amp_vel >> (AV_W - G_W)) : '0;

  env_step #(.AMP_W(AMP_W)) u_env_step (
    .state      (rd_state),
    .amp        (rd_amp),
    .peak_att   (PEAK_ATT),
    .att_step   (ATT_STEP),
    .dec_step   (DEC_STEP),
    .sus_level  (SUS_LEVEL),
    .sus_step   (SUS_STEP),
    .rel_step   (REL_STEP),
    .next_state (nxt_state),
    .next_amp   (nxt_amp)
  );

  // NOTE: the amp/phase/vel RAMs have no reset; init_q reads never-written slots as zero instead.
  always_ff @(posedge CLK) begin
    if (stage0) begin
      amp_mem[idx_q]   <= nxt_amp;
      phase_mem[idx_q] <= nxt_phase;
    end else if (note_on) begin
      amp_mem[cmd_key]   <= '0;
      phase_mem[cmd_key] <= '0;
      vel_mem[cmd_key]   <= cmd.CMD_VEL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_VOICES; i++) state_mem[i] <= ENV_IDLE;
      init_q <= '0;
    end else if (stage0) begin
      state_mem[idx_q] <= nxt_state;
    end else if (cmd_fire) begin
      if (note_on) begin
        state_mem[cmd_key] <= ENV_ATTACK;
        init_q[cmd_key]    <= 1'b1;
      end else if (state_mem[cmd_key] != ENV_IDLE) begin
        state_mem[cmd_key] <= ENV_RELEASE;
      end
    end
  end

  // Stage 1: weight the returning wavetable sample and saturate into the mix.
  logic                        s1_valid;
  logic [G_W-1:0]              s1_g;
  logic signed [ACC_W-1:0]     acc_q, acc_next, contrib;
  logic signed [CONTRIB_W-1:0] contrib_p;
  logic signed [ACC_W:0]       acc_sum;

  assign contrib_p = WAVE_DATA * $signed({1'b0, s1_g});
  assign contrib   = {{(ACC_W - CONTRIB_W){contrib_p[CONTRIB_W-1]}}, contrib_p};
  assign acc_sum   = {acc_q[ACC_W-1], acc_q} + {contrib[ACC_W-1], contrib};

  always_comb begin
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid     <= 1'b0;
      s1_g         <= '0;
      acc_q        <= '0;
      SAMPLE       <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      s1_valid     <= stage0;
      s1_g         <= g_d;
      if (TICK && BUSY) OVERRUN <= 1'b1;
      if (tick_start)    acc_q <= '0;
      else if (s1_valid) acc_q <= acc_next;
      if (sw_q == SW_DRAIN) begin
        SAMPLE       <= acc_next;
        SAMPLE_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_sweep_engine.sv
// Self-checking bench for voice_sweep_engine against a behavioural voice model.
module tb_voice_sweep_engine;

  localparam int NV = 128, PW = 24, AW = 21, SW = 16, CW = 32, DW = 12, KW = 7;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;
  localparam int ST_IDLE = 0, ST_ATTACK = 1, ST_DECAY = 2, ST_SUSTAIN = 3, ST_RELEASE = 4;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [KW-1:0] f_key;
  logic [PW-1:0] f_step;
  logic [13:0]   bend = 14'd8192;
  logic [AW-1:0] peak_att = '0, att_step = '0, dec_step = '0;
  logic [AW-1:0] sus_level = '0, sus_step = '0, rel_step = '0;
  logic [DW-1:0] wave_addr;
  logic signed [SW-1:0] wave_data = '0;
  logic signed [CW-1:0] sample;
  logic sample_valid, busy, overrun;

  logic [PW-1:0]        step_tab [NV];
  logic signed [SW-1:0] wt [1 << DW];

  voice_sweep_engine_if #(.KEY_W(KW)) cmd_bus ();

  voice_sweep_engine dut (
    .CLK(clk), .RESET(rst), .TICK(tick), .cmd(cmd_bus),
    .F_KEY(f_key), .F_STEP(f_step), .BEND(bend),
    .PEAK_ATT(peak_att), .ATT_STEP(att_step), .DEC_STEP(dec_step),
    .SUS_LEVEL(sus_level), .SUS_STEP(sus_step), .REL_STEP(rel_step),
    .WAVE_ADDR(wave_addr), .WAVE_DATA(wave_data),
    .SAMPLE(sample), .SAMPLE_VALID(sample_valid), .BUSY(busy), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;
  assign f_step = step_tab[f_key];
  always @(posedge clk) wave_data <= wt[wave_addr];

  int errors = 0, checks = 0;
  logic [DW-1:0] last_addr0;

  // Behavioural voice model
  int     m_state [NV];
  longint m_amp [NV], m_phase [NV];
  int     m_vel [NV];

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      m_state[k] = ST_IDLE; m_amp[k] = 0; m_phase[k] = 0; m_vel[k] = 0;
    end
  endtask

  task automatic model_cmd(input int key, input bit on, input int vel);
    if (on && vel != 0) begin
      m_vel[key] = vel; m_amp[key] = 0; m_phase[key] = 0; m_state[key] = ST_ATTACK;
    end else if (m_state[key] != ST_IDLE) begin
      m_state[key] = ST_RELEASE;
    end
  endtask

  task automatic model_sweep(output longint exp);
    longint acc, g, a, inc, pk, at, dc, sl, ss, rl;
    pk = longint'(peak_att); at = longint'(att_step); dc = longint'(dec_step);
    sl = longint'(sus_level); ss = longint'(sus_step); rl = longint'(rel_step);
    acc = 0;
    for (int k = 0; k < NV; k++) begin
      if (m_state[k] != ST_IDLE) begin
        g = (m_amp[k] * m_vel[k]) / 16384;
        acc = acc + longint'(wt[int'(m_phase[k] / 4096)]) * g;
        if (acc > ACC_MAX) acc = ACC_MAX;
        else if (acc < ACC_MIN) acc = ACC_MIN;
        inc = (longint'(step_tab[k]) * longint'(bend)) / 8192;
        m_phase[k] = (m_phase[k] + inc) % 64'sd16777216;
        case (m_state[k])
          ST_ATTACK: begin
            a = m_amp[k] + at;
            if (a >= pk) begin m_amp[k] = pk; m_state[k] = ST_DECAY; end
            else m_amp[k] = a;
          end
          ST_DECAY:
            if (m_amp[k] <= sl + dc) begin m_amp[k] = sl; m_state[k] = ST_SUSTAIN; end
            else m_amp[k] = m_amp[k] - dc;
          ST_SUSTAIN:
            if (m_amp[k] <= ss) begin m_amp[k] = 0; m_state[k] = ST_IDLE; end
            else m_amp[k] = m_amp[k] - ss;
          ST_RELEASE:
            if (m_amp[k] <= rl) begin m_amp[k] = 0; m_state[k] = ST_IDLE; end
            else m_amp[k] = m_amp[k] - rl;
          default: ;
        endcase
      end
    end
    exp = acc;
  endtask

  // Stimulus helpers
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick = 1'b0; cmd_bus.CMD_VALID = 1'b0;
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_env(input int pk, input int at, input int dc, input int sl, input int ss, input int rl);
    peak_att = AW'(pk); att_step = AW'(at); dec_step = AW'(dc);
    sus_level = AW'(sl); sus_step = AW'(ss); rel_step = AW'(rl);
  endtask

  task automatic fill_wt(input int v);
    for (int i = 0; i < (1 << DW); i++) wt[i] = SW'(v);
  endtask

  task automatic send_cmd(input int key, input bit on, input int vel);
    cmd_bus.CMD_KEY = KW'(key); cmd_bus.CMD_ON = on; cmd_bus.CMD_VEL = 7'(vel);
    cmd_bus.CMD_VALID = 1'b1;
    checks++;
    if (cmd_bus.CMD_READY !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_bus.CMD_READY);
    end
    step();
    cmd_bus.CMD_VALID = 1'b0;
    model_cmd(key, on, vel);
  endtask

  // One full sweep from idle, optionally with a command in the TICK cycle.
  task automatic do_tick(input string name, input bit with_cmd, input int key, input bit on,
                         input int vel, output logic [CW-1:0] got);
    longint exp; logic [CW-1:0] e; int cnt;
    tick = 1'b1;
    if (with_cmd) begin
      cmd_bus.CMD_KEY = KW'(key); cmd_bus.CMD_ON = on; cmd_bus.CMD_VEL = 7'(vel);
      cmd_bus.CMD_VALID = 1'b1;
      model_cmd(key, on, vel);
    end
    model_sweep(exp);
    e = exp[CW-1:0];
    step();
    tick = 1'b0; cmd_bus.CMD_VALID = 1'b0; cnt = 1;
    last_addr0 = wave_addr;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b want 1", name, busy); end
    while (sample_valid !== 1'b1 && cnt < 200) begin step(); cnt++; end
    checks++;
    if (cnt != NV + 2) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cnt, NV + 2); end
    checks++;
    if (sample !== e) begin errors++; $display("FAIL %s sample: got %h want %h", name, sample, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_drop: got %b want 0", name, busy); end
    got = sample;
  endtask

  // Tests
  task automatic test_reset();
    logic [CW-1:0] got;
    apply_reset();
    checks += 5;
    if (sample !== '0)            begin errors++; $display("FAIL rst_sample: got %h want 0", sample); end
    if (sample_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (overrun !== 1'b0)         begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    if (cmd_bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_bus.CMD_READY); end
    do_tick("reset_tick", 0, 0, 0, 0, got);
    checks += 2;
    if (got !== '0)       begin errors++; $display("FAIL reset_tick_zero: got %h want 0", got); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_tick_overrun: got %b want 0", overrun); end
    step();
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b want 0", sample_valid); end
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    tick = 1'b1; step(); tick = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    for (int i = 0; i < NV + 10; i++) begin
      if (sample_valid === 1'b1) seen = 1;
      step();
    end
    checks += 2;
    if (seen)          begin errors++; $display("FAIL abort_valid: got 1 want 0"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_attack();
    logic [CW-1:0] got;
    int want [5] = '{0, 203200, 406400, 609600, 812800};
    apply_reset();
    fill_wt(100);
    for (int i = 0; i < NV; i++) step_tab[i] = '0;
    bend = 14'd8192;
    set_env(32'h100000, 32'h40000, 32'h10000, 32'h80000, 0, 32'h1000);
    send_cmd(5, 1, 127);
    for (int t = 0; t < 5; t++) begin
      do_tick("attack", 0, 0, 0, 0, got);
      checks++;
      if (got !== CW'(want[t])) begin
        errors++; $display("FAIL attack_tick%0d: got %0d want %0d", t, $signed(got), want[t]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] got;
    apply_reset();
    fill_wt(16'h7FFF);
    set_env(32'h1FFFFF, 32'h1FFFFF, 0, 32'h1FFFFF, 0, 0);
    for (int k = 0; k < NV; k++) send_cmd(k, 1, 127);
    do_tick("sat_ramp", 0, 0, 0, 0, got);
    do_tick("sat_pos", 0, 0, 0, 0, got);
    checks++;
    if (got !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_pos_clamp: got %h want 7fffffff", got); end
    fill_wt(16'h8000);
    do_tick("sat_neg", 0, 0, 0, 0, got);
    checks++;
    if (got !== 32'h80000000) begin errors++; $display("FAIL sat_neg_clamp: got %h want 80000000", got); end
  endtask

  task automatic test_phase_wrap();
    logic [CW-1:0] got;
    logic [DW-1:0] want;
    apply_reset();
    for (int i = 0; i < (1 << DW); i++) wt[i] = SW'($urandom);
    step_tab[0] = 24'h800000;
    bend = 14'd8192;
    set_env(32'h1FFFFF, 1, 0, 0, 0, 0);
    send_cmd(0, 1, 64);
    for (int t = 0; t < 4; t++) begin
      do_tick("phase_wrap", 0, 0, 0, 0, got);
      want = (t % 2 == 0) ? 12'h000 : 12'h800;
      checks++;
      if (last_addr0 !== want) begin
        errors++; $display("FAIL phase_wrap_addr%0d: got %h want %h", t, last_addr0, want);
      end
    end
  endtask

  task automatic test_release();
    logic [CW-1:0] got;
    for (int mode = 0; mode < 2; mode++) begin
      apply_reset();
      fill_wt(50);
      for (int i = 0; i < NV; i++) step_tab[i] = 24'h1234;
      set_env(32'h100000, 32'h100000, 32'h100, 32'h10000, 0, 0);
      send_cmd(9, 1, 100);
      do_tick("rel_attack", 0, 0, 0, 0, got);
      do_tick("rel_decay", 0, 0, 0, 0, got);
      if (mode == 0) send_cmd(9, 0, 55);
      else           send_cmd(9, 1, 0);
      rel_step = AW'(m_amp[9] / 2);
      do_tick("rel_1", 0, 0, 0, 0, got);
      checks++;
      if (got !== 32'd319900) begin errors++; $display("FAIL rel_1_m%0d: got %0d want 319900", mode, got); end
      do_tick("rel_2", 0, 0, 0, 0, got);
      checks++;
      if (got !== 32'd159950) begin errors++; $display("FAIL rel_2_m%0d: got %0d want 159950", mode, got); end
      do_tick("rel_idle", 0, 0, 0, 0, got);
      checks++;
      if (got !== '0) begin errors++; $display("FAIL rel_idle_m%0d: got %h want 0", mode, got); end
    end
  endtask

  task automatic test_busy_cmd();
    logic [CW-1:0] got, e;
    longint exp;
    int cyc = 1, acc_cyc = -1, sv_cyc = -1;
    bit accepted = 0;
    apply_reset();
    for (int i = 0; i < (1 << DW); i++) wt[i] = SW'($urandom);
    for (int i = 0; i < NV; i++) step_tab[i] = PW'($urandom_range(0, 32'h3FFFF));
    set_env(32'h180000, 32'h30000, 32'h2000, 32'h90000, 32'h100, 32'h8000);
    send_cmd(2, 1, 120);
    do_tick("busy_pre", 0, 0, 0, 0, got);
    tick = 1'b1;
    model_sweep(exp);
    e = exp[CW-1:0];
    step();
    tick = 1'b0;
    cmd_bus.CMD_KEY = 7'd3; cmd_bus.CMD_ON = 1'b1; cmd_bus.CMD_VEL = 7'd90; cmd_bus.CMD_VALID = 1'b1;
    while (!accepted && cyc < 300) begin
      if (cyc == 5) begin
        checks++;
        if (cmd_bus.CMD_READY !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", cmd_bus.CMD_READY); end
      end
      tick = (cyc == 10);
      if (sample_valid === 1'b1) begin
        sv_cyc = cyc;
        checks++;
        if (sample !== e) begin errors++; $display("FAIL busy_sample: got %h want %h", sample, e); end
      end
      if (cmd_bus.CMD_READY === 1'b1) begin accepted = 1; acc_cyc = cyc; end
      step();
      cyc++;
    end
    cmd_bus.CMD_VALID = 1'b0; tick = 1'b0;
    model_cmd(3, 1, 90);
    checks += 3;
    if (sv_cyc != NV + 2)  begin errors++; $display("FAIL busy_valid_cycle: got %0d want %0d", sv_cyc, NV + 2); end
    if (acc_cyc != NV + 2) begin errors++; $display("FAIL busy_accept_cycle: got %0d want %0d", acc_cyc, NV + 2); end
    if (overrun !== 1'b1)  begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    do_tick("busy_post", 0, 0, 0, 0, got);
    do_tick("same_cycle", 1, 7, 1, 77, got);
    do_tick("same_cycle_next", 0, 0, 0, 0, got);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_random();
    logic [CW-1:0] got;
    int pk;
    apply_reset();
    for (int i = 0; i < (1 << DW); i++) wt[i] = SW'($urandom);
    for (int i = 0; i < NV; i++) step_tab[i] = PW'($urandom_range(0, 32'hFFFFF));
    for (int t = 0; t < 25; t++) begin
      if (t % 5 == 0) begin
        pk = $urandom_range(32'h10000, 32'h1FFFFF);
        set_env(pk, $urandom_range(1, pk), $urandom_range(0, 32'h40000), $urandom_range(0, pk),
                $urandom_range(0, 32'h800), $urandom_range(0, 32'h40000));
        bend = 14'($urandom_range(0, 16383));
      end
      for (int c = 0; c < int'($urandom_range(0, 4)); c++)
        send_cmd($urandom_range(0, NV - 1), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 127));
      do_tick("random", 1'($urandom_range(0, 1)), $urandom_range(0, NV - 1),
              1'($urandom_range(0, 1)), $urandom_range(0, 127), got);
    end
  endtask

  initial begin
    cmd_bus.CMD_VALID = 1'b0; cmd_bus.CMD_KEY = '0; cmd_bus.CMD_ON = 1'b0; cmd_bus.CMD_VEL = '0;
    for (int i = 0; i < NV; i++) step_tab[i] = '0;
    fill_wt(0);
    model_reset();
    test_reset();
    test_reset_abort();
    test_attack();
    test_saturation();
    test_phase_wrap();
    test_release();
    test_busy_cmd();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
